// File: rtl/match_detector_pkg.sv
// Shared encodings for the serial pattern detector and the run controller
// that consumes its match/halt flags.
package match_detector_pkg;

  typedef enum logic [1:0] {
    ST_FILL   = 2'b00,
    ST_RUN    = 2'b01,
    ST_HALTED = 2'b10
  } det_state_e;

  typedef enum logic [1:0] {
    CTRL_IDLE  = 2'b00,
    CTRL_MATCH = 2'b01,
    CTRL_HALT  = 2'b10
  } ctrl_state_e;

endpackage

// File: rtl/match_window.sv
// PAT_W-bit serial shift window with fill counter and pattern comparator.
// window_full/window_eq describe the window as it will be after this edge.
module match_window #(
  parameter int unsigned PAT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             data_in,
  input  logic [PAT_W-1:0] pattern,
  output logic             window_full,
  output logic             window_eq
);

  localparam int unsigned FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(PAT_W);

  logic [PAT_W-1:0] window_q, window_d;
  logic [FW-1:0]    fill_q, fill_d;

  always_comb begin
    window_d = window_q;
    fill_d   = fill_q;
    if (shift_en) begin
      window_d = {window_q[PAT_W-2:0], data_in};
      if (fill_q != FILL_MAX) begin
        fill_d = fill_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      window_q <= '0;
      fill_q   <= '0;
    end else if (clear) begin
      window_q <= '0;
      fill_q   <= '0;
    end else begin
      window_q <= window_d;
      fill_q   <= fill_d;
    end
  end

  assign window_full = (fill_d == FILL_MAX);
  assign window_eq   = (window_d == pattern);

endmodule

// File: rtl/match_detector.sv
// Serial pattern detector: flags window==pattern, counts qualified symbols
// and raises a sticky halt once the count reaches HALT_COUNT.
module match_detector
  import match_detector_pkg::*;
#(
  parameter int unsigned PAT_W      = 4,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned HALT_COUNT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_in,
  input  logic             data_valid,
  input  logic [PAT_W-1:0] pattern,
  input  logic             enable_count,
  input  logic             clear,
  output logic             match_flag,
  output logic             halt_flag,
  output logic [CNT_W-1:0] match_count
);

  localparam logic [CNT_W-1:0] HALT_VAL = CNT_W'(HALT_COUNT);

  det_state_e       state_q;
  logic             match_q;
  logic             halt_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             active, shift_en, inc, halt_hit;
  logic             window_full, window_eq;

  assign active   = (state_q != ST_HALTED);
  assign shift_en = active && data_valid;
  assign inc      = active && data_valid && enable_count;
  assign count_d  = count_q + 1'b1;
  assign halt_hit = inc && (count_d == HALT_VAL);

  match_window #(
    .PAT_W(PAT_W)
  ) u_window (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .shift_en   (shift_en),
    .data_in    (data_in),
    .pattern    (pattern),
    .window_full(window_full),
    .window_eq  (window_eq)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_FILL;
      match_q <= 1'b0;
      halt_q  <= 1'b0;
      count_q <= '0;
    end else if (clear) begin
      state_q <= ST_FILL;
      match_q <= 1'b0;
      halt_q  <= 1'b0;
      count_q <= '0;
    end else begin
      case (state_q)
        ST_FILL, ST_RUN: begin
          if (inc) begin
            count_q <= count_d;
          end
          // Halt wins over the fill-complete transition on the same edge.
          if (halt_hit) begin
            state_q <= ST_HALTED;
            halt_q  <= 1'b1;
            match_q <= 1'b0;
          end else if (window_full) begin
            state_q <= ST_RUN;
            match_q <= window_eq;
          end else begin
            match_q <= 1'b0;
          end
        end
        ST_HALTED: begin
          match_q <= 1'b0;
        end
        default: begin
          state_q <= ST_FILL;
          match_q <= 1'b0;
        end
      endcase
    end
  end

  assign match_flag  = match_q;
  assign halt_flag   = halt_q;
  assign match_count = count_q;

endmodule

// File: tb/tb_match_detector.sv
// Directed and randomized bench for match_detector against a queue-based
// reference model, with a small behavioural run controller for closed loop.
module tb_match_detector;
  import match_detector_pkg::*;

  localparam int PAT_W = 4;
  localparam int CNT_W = 8;
  localparam int HALT_COUNT = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             data_in;
  logic             data_valid;
  logic [PAT_W-1:0] pattern;
  logic             enable_count;
  logic             clear;
  logic             match_flag;
  logic             halt_flag;
  logic [CNT_W-1:0] match_count;

  int errors = 0;
  int checks = 0;

  // reference model state
  bit m_bits[$];
  int m_cnt;
  bit m_halt;
  bit m_match;

  ctrl_state_e ctrl, ctrl_nxt;
  bit          loop_mode;

  match_detector #(
    .PAT_W(PAT_W),
    .CNT_W(CNT_W),
    .HALT_COUNT(HALT_COUNT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .pattern     (pattern),
    .enable_count(enable_count),
    .clear       (clear),
    .match_flag  (match_flag),
    .halt_flag   (halt_flag),
    .match_count (match_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".match"}, {31'd0, match_flag}, {31'd0, m_match});
    check({tag, ".halt"},  {31'd0, halt_flag},  {31'd0, m_halt});
    check({tag, ".count"}, {24'd0, match_count}, m_cnt);
  endtask

  function automatic bit model_window_eq();
    logic [PAT_W-1:0] v;
    if (m_bits.size() < PAT_W) return 1'b0;
    for (int i = 0; i < PAT_W; i++) v[PAT_W-1-i] = m_bits[i];
    return v == pattern;
  endfunction

  task automatic model_reset();
    m_bits.delete();
    m_cnt = 0;
    m_halt = 1'b0;
    m_match = 1'b0;
  endtask

  task automatic model_update();
    if (clear) begin
      model_reset();
    end else if (m_halt) begin
      m_match = 1'b0;
    end else begin
      if (data_valid) begin
        m_bits.push_back(data_in);
        if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
      end
      if (data_valid && enable_count) m_cnt++;
      if (m_cnt == HALT_COUNT) begin
        m_halt = 1'b1;
        m_match = 1'b0;
      end else begin
        m_match = model_window_eq();
      end
    end
  endtask

  // One clock: update model from pre-edge inputs, advance, then check.
  task automatic cycle(input string tag);
    model_update();
    case (ctrl)
      CTRL_IDLE:  ctrl_nxt = match_flag ? CTRL_MATCH : CTRL_IDLE;
      CTRL_MATCH: ctrl_nxt = halt_flag ? CTRL_HALT : CTRL_MATCH;
      CTRL_HALT:  ctrl_nxt = halt_flag ? CTRL_HALT : CTRL_IDLE;
      default:    ctrl_nxt = CTRL_IDLE;
    endcase
    @(posedge clk);
    #1;
    ctrl = ctrl_nxt;
    if (loop_mode) enable_count = (ctrl == CTRL_MATCH);
    check_model(tag);
  endtask

  task automatic drive(input logic d, input logic v, input logic e, input logic c);
    data_in = d;
    data_valid = v;
    enable_count = e;
    clear = c;
  endtask

  initial begin
    logic [3:0] seq;
    model_reset();
    ctrl = CTRL_IDLE;
    loop_mode = 1'b0;
    pattern = 4'b1011;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    #12;
    check("reset.match", {31'd0, match_flag}, 32'd0);
    check("reset.halt", {31'd0, halt_flag}, 32'd0);
    check("reset.count", {24'd0, match_count}, 32'd0);
    reset = 1'b0;

    // basic match 1011
    seq = 4'b1011;
    for (int i = 3; i >= 0; i--) begin
      drive(seq[i], 1'b1, 1'b0, 1'b0);
      cycle("basic");
      if (i != 0) check("fill_no_match", {31'd0, match_flag}, 32'd0);
    end
    check("basic_match", {31'd0, match_flag}, 32'd1);

    // non-match then hold
    seq = 4'b1010;
    for (int i = 3; i >= 0; i--) begin
      drive(seq[i], 1'b1, 1'b0, 1'b0);
      cycle("nonmatch");
    end
    check("nonmatch_flag", {31'd0, match_flag}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      cycle("hold");
    end

    // halt at HALT_COUNT
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      cycle("halt_ramp");
      check("halt_ramp_count", {24'd0, match_count}, i);
      check("halt_ramp_flag", {31'd0, halt_flag}, (i == 3) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      cycle("halted");
    end
    check("halted_count", {24'd0, match_count}, 32'd3);
    check("halted_match", {31'd0, match_flag}, 32'd0);

    // clear wins over the halting increment
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    cycle("clear0");
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      cycle("pre_clear");
    end
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    cycle("clear_prio");
    check("clear_prio_count", {24'd0, match_count}, 32'd0);
    check("clear_prio_halt", {31'd0, halt_flag}, 32'd0);
    seq = 4'b1011;
    for (int i = 3; i >= 0; i--) begin
      drive(seq[i], 1'b1, 1'b0, 1'b0);
      cycle("refill");
    end
    check("refill_match", {31'd0, match_flag}, 32'd1);

    // closed loop with controller
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    cycle("loop_clear");
    ctrl = CTRL_IDLE;
    loop_mode = 1'b1;
    enable_count = 1'b0;
    clear = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      data_in = seq[i];
      data_valid = 1'b1;
      cycle("loop_pat");
    end
    for (int i = 0; i < 9; i++) begin
      data_in = 1'b1;
      data_valid = 1'b1;
      cycle("loop_run");
    end
    check("loop_ctrl_halt", {30'd0, ctrl}, {30'd0, CTRL_HALT});
    check("loop_halt_flag", {31'd0, halt_flag}, 32'd1);
    clear = 1'b1;
    cycle("loop_clear2");
    clear = 1'b0;
    cycle("loop_after");
    check("loop_ctrl_idle", {30'd0, ctrl}, {30'd0, CTRL_IDLE});
    loop_mode = 1'b0;

    // async reset mid-stream
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      cycle("pre_reset");
    end
    check("pre_reset_count", {24'd0, match_count}, 32'd2);
    #2 reset = 1'b1;
    #1;
    check("async_match", {31'd0, match_flag}, 32'd0);
    check("async_halt", {31'd0, halt_flag}, 32'd0);
    check("async_count", {24'd0, match_count}, 32'd0);
    model_reset();
    ctrl = CTRL_IDLE;
    #1 reset = 1'b0;

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      clear = ($urandom_range(0, 19) == 0);
      if (clear) pattern = 4'($urandom_range(0, 15));
      data_in = 1'($urandom_range(0, 1));
      data_valid = ($urandom_range(0, 3) != 0);
      enable_count = ($urandom_range(0, 3) == 0);
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
